// File: rtl/uart_pkg.sv
// Shared UART types and constants: parity modes, TX/RX FSM states, oversampling ratio.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/level.
// Latency: pushed word visible at pop_data the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX and RX FIFOs, configurable width/parity/stop bits/baud.
// Latency: TX start bit 2 cycles after push into idle engine; RX word valid 1 cycle after stop mid-sample.
// Backpressure: tx_ready drops when TX FIFO full; RX words arriving into a full FIFO are dropped and flagged.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 26,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic                          txd,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_overrun,
    input  logic                          clr_err,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

    localparam int                DIV_W       = $clog2(CLK_DIV);
    localparam parity_e           PAR_MODE    = parity_e'(PARITY[1:0]);
    localparam logic              PAR_EN      = (PAR_MODE != PAR_NONE);
    localparam logic              PAR_INV     = (PAR_MODE == PAR_ODD);
    localparam logic [DIV_W-1:0]  DIV_MAX     = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_MID    = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        DATA_LAST   = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST   = 3'(STOP_BITS - 1);

    // ---------------- TX path ----------------
    tx_state_e             tx_state;
    tx_state_e             tx_nxt;
    logic [DIV_W-1:0]      tx_div;
    logic [TICK_W-1:0]     tx_tick;
    logic [2:0]            tx_idx;
    logic [DATA_BITS-1:0]  tx_sh;
    logic [DATA_BITS-1:0]  tx_head;
    logic                  tx_par;
    logic                  tx_pop;
    logic                  tx_empty;
    logic                  tx_full;
    logic                  tx_bit_end;
    logic                  txd_q;

    assign tx_ready   = !tx_full;
    assign txd        = txd_q;
    assign tx_bit_end = (tx_div == DIV_MAX) && (tx_tick == TICK_LAST);

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    // TX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_nxt;
    end

    // TX next state; the last stop bit chains straight into the next start bit when work is queued.
    always_comb begin
        tx_nxt = tx_state;
        tx_pop = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop = 1'b1;
                    tx_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) tx_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end && tx_idx == DATA_LAST) tx_nxt = PAR_EN ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                if (tx_bit_end) tx_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end && tx_idx == STOP_LAST) begin
                    if (!tx_empty) begin
                        tx_pop = 1'b1;
                        tx_nxt = TX_START;
                    end else begin
                        tx_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    // TX bit timing, shift register and registered line driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_div  <= '0;
            tx_tick <= '0;
            tx_idx  <= '0;
            tx_sh   <= '0;
            tx_par  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            if (tx_state == TX_IDLE) begin
                tx_div  <= '0;
                tx_tick <= '0;
            end else if (tx_div == DIV_MAX) begin
                tx_div  <= '0;
                tx_tick <= tx_tick + 1'b1;
            end else begin
                tx_div  <= tx_div + 1'b1;
            end

            if (tx_nxt != tx_state) tx_idx <= '0;
            else if (tx_bit_end)    tx_idx <= tx_idx + 1'b1;

            if (tx_pop) begin
                tx_sh  <= tx_head;
                tx_par <= (^tx_head) ^ PAR_INV;
            end else if (tx_state == TX_DATA && tx_bit_end) begin
                tx_sh  <= tx_sh >> 1;
            end

            case (tx_state)
                TX_START:  txd_q <= 1'b0;
                TX_DATA:   txd_q <= tx_sh[0];
                TX_PARITY: txd_q <= tx_par;
                default:   txd_q <= 1'b1;
            endcase
        end
    end

    // ---------------- RX path ----------------
    rx_state_e             rx_state;
    rx_state_e             rx_nxt;
    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic [DIV_W-1:0]      rx_div;
    logic [TICK_W-1:0]     rx_tick;
    logic [2:0]            rx_idx;
    logic [DATA_BITS-1:0]  rx_sh;
    logic                  rx_par_err;
    logic                  rx_push;
    logic                  rx_sample;
    logic                  rx_bit_end;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_pop;
    logic [DATA_BITS+1:0]  rx_head;

    assign rx_s       = rx_sync[1];
    assign rx_sample  = (rx_div == '0) && (rx_tick == TICK_MID);
    assign rx_bit_end = (rx_div == DIV_MAX) && (rx_tick == TICK_LAST);
    assign rx_valid   = !rx_empty;
    assign rx_pop     = rx_valid && rx_ready;
    assign {rx_frame_err, rx_parity_err, rx_data} = rx_head;

    uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data ({~rx_s, rx_par_err, rx_sh}),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    // Two-flop synchroniser; resets to the idle line level so no false start follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], rxd};
    end

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_nxt;
    end

    // RX next state; leaves the stop bit one tick early to leave margin for the next start edge.
    always_comb begin
        rx_nxt  = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s) rx_nxt = RX_START;
            end
            RX_START: begin
                if (rx_sample && rx_s) rx_nxt = RX_IDLE;
                else if (rx_bit_end)   rx_nxt = RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end && rx_idx == DATA_LAST) rx_nxt = PAR_EN ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (rx_bit_end) rx_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (rx_sample && rx_idx == 3'd0) rx_push = 1'b1;
                if (rx_idx == STOP_LAST && rx_div == '0 && rx_tick == TICK_LAST) rx_nxt = RX_IDLE;
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // RX oversample timing, data capture and parity check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_div     <= '0;
            rx_tick    <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_par_err <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE) begin
                rx_div  <= '0;
                rx_tick <= '0;
            end else if (rx_div == DIV_MAX) begin
                rx_div  <= '0;
                rx_tick <= rx_tick + 1'b1;
            end else begin
                rx_div  <= rx_div + 1'b1;
            end

            if (rx_nxt != rx_state) rx_idx <= '0;
            else if (rx_bit_end)    rx_idx <= rx_idx + 1'b1;

            if (rx_state == RX_DATA && rx_sample) rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};

            if (rx_state == RX_START)                      rx_par_err <= 1'b0;
            else if (rx_state == RX_PARITY && rx_sample)   rx_par_err <= rx_s ^ (^rx_sh) ^ PAR_INV;
        end
    end

    // Sticky overrun flag; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  rx_overrun <= 1'b0;
        else if (rx_push && rx_full && !rx_pop)   rx_overrun <= 1'b1;
        else if (clr_err)                         rx_overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboarded bench: u0 is 8N1/depth 16, u1 is 8E1/depth 4, both CLK_DIV=4 (64 cycles per bit).
// Each instance loops txd to rxd unless the shared driven line is selected.
module tb_uart_fifo_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic drv   = 1'b1;
    logic loop0 = 1'b1;
    logic loop1 = 1'b1;

    logic       txd0, rxd0, tx_valid0, tx_ready0, rx_valid0, rx_ready0;
    logic       rx_pe0, rx_fe0, rx_ovr0, clr0;
    logic [7:0] tx_data0, rx_data0;
    logic [4:0] tx_lvl0, rx_lvl0;

    logic       txd1, rxd1, tx_valid1, tx_ready1, rx_valid1, rx_ready1;
    logic       rx_pe1, rx_fe1, rx_ovr1, clr1;
    logic [7:0] tx_data1, rx_data1;
    logic [2:0] tx_lvl1, rx_lvl1;

    assign rxd0 = loop0 ? txd0 : drv;
    assign rxd1 = loop1 ? txd1 : drv;

    uart_fifo_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .rxd(rxd0), .txd(txd0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .rx_parity_err(rx_pe0), .rx_frame_err(rx_fe0), .rx_overrun(rx_ovr0),
        .clr_err(clr0), .tx_level(tx_lvl0), .rx_level(rx_lvl0)
    );

    uart_fifo_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .rxd(rxd1), .txd(txd1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .rx_parity_err(rx_pe1), .rx_frame_err(rx_fe1), .rx_overrun(rx_ovr1),
        .clr_err(clr1), .tx_level(tx_lvl1), .rx_level(rx_lvl1)
    );

    int total = 0;
    int bad   = 0;

    // Expected RX words as {frame_err, parity_err, data}.
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: compare the FIFO head on every handshake that will fire at the next edge.
    always @(negedge clk) begin
        if (!rst && rx_valid0 && rx_ready0) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx0_unexpected: got %0h expected none", {rx_fe0, rx_pe0, rx_data0});
            end else begin
                chk("rx0_word", int'({rx_fe0, rx_pe0, rx_data0}), int'(q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rx_valid1 && rx_ready1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx1_unexpected: got %0h expected none", {rx_fe1, rx_pe1, rx_data1});
            end else begin
                chk("rx1_word", int'({rx_fe1, rx_pe1, rx_data1}), int'(q1.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] d);
        int n = 0;
        while (!tx_ready0 && n < 5000) begin
            cyc(1);
            n++;
        end
        if (n == 5000) chk("tx0_ready_wait", 0, 1);
        tx_data0  = d;
        tx_valid0 = 1'b1;
        cyc(1);
        tx_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [7:0] d);
        int n = 0;
        while (!tx_ready1 && n < 5000) begin
            cyc(1);
            n++;
        end
        if (n == 5000) chk("tx1_ready_wait", 0, 1);
        tx_data1  = d;
        tx_valid1 = 1'b1;
        cyc(1);
        tx_valid1 = 1'b0;
    endtask

    // Drive n serial bits from bits[0] upward, 64 cycles each, then return the line to idle.
    task automatic drive_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drv = bits[i];
            cyc(64);
        end
        drv = 1'b1;
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk("q0_drained", q0.size(), 0);
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk("q1_drained", q1.size(), 0);
    endtask

    logic [19:0] exp_bits;
    int          first;
    int          second;
    int          bi;
    int          lows;

    initial begin
        tx_data0 = '0; tx_valid0 = 1'b0; rx_ready0 = 1'b1; clr0 = 1'b0;
        tx_data1 = '0; tx_valid1 = 1'b0; rx_ready1 = 1'b1; clr1 = 1'b0;

        // Reset state.
        cyc(3);
        chk("rst_txd0", txd0, 1);
        chk("rst_tx_ready0", tx_ready0, 1);
        chk("rst_rx_valid0", rx_valid0, 0);
        chk("rst_overrun0", rx_ovr0, 0);
        chk("rst_tx_level0", tx_lvl0, 0);
        chk("rst_rx_level0", rx_lvl0, 0);
        chk("rst_txd1", txd1, 1);
        chk("rst_rx_valid1", rx_valid1, 0);
        rst = 1'b0;
        cyc(5);

        // 8N1 loopback: 0x55 then 0xA3, line pattern, latency and zero gap.
        q0.push_back({2'b00, 8'h55});
        q0.push_back({2'b00, 8'hA3});
        exp_bits = {10'b1101000110, 10'b1010101010};
        first  = -1;
        second = -1;
        bi     = 0;
        push0(8'h55);
        push0(8'hA3);
        for (int k = 1; k <= 2000 && bi < 20; k++) begin
            @(negedge clk);
            if (first < 0) begin
                if (!txd0) first = k;
            end else begin
                if ((k - first) == 32 + 64 * bi) begin
                    chk($sformatf("txd_bit%0d", bi), txd0, exp_bits[bi]);
                    bi++;
                end
                if (second < 0 && (k - first) > 600 && !txd0) second = k - first;
            end
        end
        chk("tx_start_latency", first, 2);
        chk("frame_to_frame", second, 640);
        #1;
        drain0();
        chk("rx0_level_empty", rx_lvl0, 0);

        // 8E1: bad parity bit on 0x07, then the correct one.
        loop1 = 1'b0;
        q1.push_back({2'b01, 8'h07});
        drive_bits({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        cyc(64);
        q1.push_back({2'b00, 8'h07});
        drive_bits({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        drain1();
        loop1 = 1'b1;

        // 8N1: stop bit low on 0x3C, then a clean 0x3C.
        loop0 = 1'b0;
        q0.push_back({2'b10, 8'h3C});
        drive_bits({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        cyc(64);
        q0.push_back({2'b00, 8'h3C});
        drive_bits({6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        drain0();

        // Short low pulse is a glitch, not a start bit.
        drv = 1'b0;
        cyc(20);
        drv = 1'b1;
        cyc(200);
        chk("glitch_rx_level", rx_lvl0, 0);
        chk("glitch_rx_valid", rx_valid0, 0);
        loop0 = 1'b1;

        // Depth-4 overrun: five words with the consumer stalled.
        rx_ready1 = 1'b0;
        for (int i = 1; i <= 4; i++) q1.push_back({2'b00, 8'(i)});
        for (int i = 1; i <= 5; i++) push1(8'(i));
        cyc(3900);
        chk("ovr_rx_level", rx_lvl1, 4);
        chk("ovr_flag_set", rx_ovr1, 1);
        chk("ovr_rx_valid", rx_valid1, 1);
        rx_ready1 = 1'b1;
        drain1();
        chk("ovr_level_drained", rx_lvl1, 0);
        chk("ovr_flag_sticky", rx_ovr1, 1);
        clr1 = 1'b1;
        cyc(1);
        clr1 = 1'b0;
        chk("ovr_flag_cleared", rx_ovr1, 0);

        // Reset during the second word's data bits.
        q0.push_back({2'b00, 8'h11});
        push0(8'h11);
        push0(8'h22);
        push0(8'h33);
        cyc(640 + 64 * 3 + 32);
        rst = 1'b1;
        #1;
        chk("mid_frame_txd_high", txd0, 1);
        chk("mid_frame_tx_level", tx_lvl0, 0);
        cyc(3);
        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!txd0) lows++;
        end
        #1;
        chk("post_rst_txd_low_cycles", lows, 0);
        chk("post_rst_tx_level", tx_lvl0, 0);
        chk("post_rst_rx_level", rx_lvl0, 0);
        chk("post_rst_rx_valid", rx_valid0, 0);
        chk("post_rst_q0_empty", q0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised full-duplex UART engine with integrated RX and TX buffering: configurable data width, parity, stop bits, baud divisor and FIFO depth. It replaces the fixed 8N1 receiver/sender pair and their external FIFO/RAM glue with one block. It presents valid/ready byte streams to the fabric and per-word error status on the receive side. It sits between the board `rxd`/`txd` pins and the packet/RAM controllers.

## Interface
- `CLK_DIV`, 26: clk cycles per oversample tick (16 ticks per bit; 26 gives ≈115200 baud at 48 MHz); ≥2.
- `DATA_BITS`, 8: payload bits per frame, 5..8.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries per FIFO, power of two, ≥2.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high. One clock domain only.
- `rxd` in 1: serial input, asynchronous to `clk`.
- `txd` out 1: serial output, idle high.
- `tx_data` in DATA_BITS: word to transmit.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: TX FIFO not full.
- `rx_data` out DATA_BITS: head of RX FIFO.
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: consumer pops the head.
- `rx_parity_err` out 1: head word's parity was wrong; qualified by `rx_valid`.
- `rx_frame_err` out 1: head word's first stop bit sampled low; qualified by `rx_valid`.
- `rx_overrun` out 1: sticky; set when a received word is dropped.
- `clr_err` in 1: clears `rx_overrun`.
- `tx_level`, `rx_level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Frame format: start (0), DATA_BITS LSB first, optional parity bit, STOP_BITS stop (1). Each bit lasts exactly 16·CLK_DIV clk cycles.
- TX FIFO: a push occurs on `tx_valid && tx_ready`. `tx_ready = !full`, taken from registered occupancy.
- TX FSM has five states.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START.
  - START → DATA (DATA_BITS bits) → PARITY (skipped if PARITY=0) → STOP (STOP_BITS bits) → IDLE.
  - Back-to-back words produce no idle gap.
- Parity bit: even mode uses XOR of the data bits; odd mode uses its inverse.
- RX input: `rxd` passes through a 2-flop synchroniser, reset to 1. The oversample counter restarts at the falling edge detected in IDLE.
- RX FSM has five states.
  - IDLE: a low sample moves to START.
  - START: sample at tick 8. High means a glitch; return to IDLE with no push.
  - DATA and PARITY: sample at tick 8 of each bit.
  - STOP: sample the first stop bit at tick 8. Push {frame_err, parity_err, data} to the RX FIFO.
  - After the push, wait to tick 15 of the last stop bit, then go to IDLE. A second stop bit is not checked.
- RX FIFO stores DATA_BITS+2 bits per entry.
- RX FIFO is first-word-fall-through. A pop occurs on `rx_valid && rx_ready`.
- RX push while full:
  - With a pop in the same cycle, the push is accepted and occupancy is unchanged.
  - Otherwise the word is dropped, `rx_overrun` is set and the FIFO contents are unchanged.
- `rx_overrun` with `clr_err` and a new overrun in the same cycle: set wins.

## Timing
- Reset values (asynchronous, applied while `rst`=1):
  - `txd`=1, `tx_ready`=1.
  - `rx_valid`=0, `rx_overrun`=0.
  - Both levels 0; both FSMs in IDLE.
  - FIFO pointers and counters 0.
- Reset mid-frame: the frame is truncated and `txd` returns high immediately. No partial RX word is pushed.
- TX latency: push at edge N with the FIFO empty and the FSM idle. The pop happens at N+1, `txd` falls at N+2, and the start bit holds for 16·CLK_DIV cycles.
- RX latency: `rx_valid` rises 1 cycle after the stop-bit mid-sample (plus 2 synchroniser cycles from the pin).
- Level outputs update in the cycle after the push/pop edge.

## Structure
- Shared package `uart_pkg` holds:
  - parity enum (NONE/EVEN/ODD);
  - TX/RX state typedefs;
  - the OVERSAMPLE=16 constant.
- Sub-module `uart_sync_fifo` (WIDTH, DEPTH): single clock, FWFT, with full/empty/level. It is instantiated twice.
- The TX FSM, RX FSM and synchroniser live in the top module.

## Test plan
Bench configuration unless stated: CLK_DIV=4 (bit = 64 cycles), `txd` looped to `rxd`.
1. 8N1: push 0x55 then 0xA3 → `txd` shows 0,1,0,1,0,1,0,1,0,1 at 64 cycles per bit; RX pops 0x55 then 0xA3 with both error bits 0; no idle gap between the frames.
2. PARITY=1: drive the 0x07 frame with parity bit 0 (correct value 1) → `rx_data`=0x07, `rx_parity_err`=1, `rx_frame_err`=0.
3. Drive the 0x3C frame with stop bit 0 → `rx_frame_err`=1; a following valid 0x3C frame is received clean.
4. Drive `rxd` low for 20 cycles (< 32), then high → no push; `rx_level` stays 0.
5. FIFO_DEPTH=4, `rx_ready`=0: send 0x01..0x05 → `rx_level`=4, `rx_overrun`=1, pops yield 0x01..0x04. Pulse `clr_err` → `rx_overrun`=0.
6. Push 3 words, assert `rst` during the second word's data bits → `txd`=1 at once; after release, `tx_level`=0 and `txd` stays idle.
